// File: rtl/atpg_vector_sequencer.sv
// Applies a loadable stimulus table to a combinational DUT and compares each captured response against an expected word under a mask.
// Defining ATPG_SEQ_MISR_EN adds a MISR signature output computed over the captured responses.
`timescale 1ns/1ps
module atpg_vector_sequencer #(
  parameter int  IN_W   = 60,
  parameter int  OUT_W  = 26,
  parameter int  DEPTH  = 16,
  parameter int  SETTLE = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [IN_W-1:0]  ld_stim,
  input  logic [OUT_W-1:0] ld_exp,
  input  logic [OUT_W-1:0] ld_mask,
  input  logic             start,
  input  logic [AW:0]      num_vec,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [AW-1:0]    cap_addr,
  output logic [OUT_W-1:0] cap_data,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [AW:0]      fail_count,
  output logic [AW-1:0]    first_fail
`ifdef ATPG_SEQ_MISR_EN
  ,
  output logic [OUT_W-1:0] signature
`endif
);

  // state     | meaning
  // S_IDLE    | waiting for start, table writable
  // S_APPLY   | register stim[idx] onto dut_in, load settle counter
  // S_SETTLE  | let the DUT outputs settle for SETTLE cycles
  // S_CAPTURE | store response, masked compare, advance index
  // S_FINISH  | run complete, done pulses on the following cycle
  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_FINISH
  } state_t;

  localparam logic [AW:0] DEPTH_V  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_V    = (AW + 1)'(1);
  localparam logic [3:0]  SETTLE_V = 4'(SETTLE);

  logic [IN_W-1:0]  stim_mem [DEPTH];
  logic [OUT_W-1:0] exp_mem  [DEPTH];
  logic [OUT_W-1:0] mask_mem [DEPTH];
  logic [OUT_W-1:0] cap_mem  [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW:0]      n_q, n_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic             fail_q, fail_d;
  logic [AW:0]      fail_count_q, fail_count_d;
  logic [AW-1:0]    first_fail_q, first_fail_d;
  logic             done_q, done_d;
  logic             tbl_we, cap_we;
  logic             mismatch, last_vec;
`ifdef ATPG_SEQ_MISR_EN
  logic [OUT_W-1:0] sig_q, sig_d;
`endif

  assign mismatch = |((dut_out ^ exp_mem[idx_q]) & mask_mem[idx_q]);
  assign last_vec = ({1'b0, idx_q} == (n_q - ONE_V));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    dut_in_d     = dut_in_q;
    fail_d       = fail_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    done_d       = 1'b0;
    tbl_we       = 1'b0;
    cap_we       = 1'b0;
`ifdef ATPG_SEQ_MISR_EN
    sig_d        = sig_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A write coinciding with start is dropped so the run sees the old word.
        if (start) begin
          idx_d        = '0;
          fail_d       = 1'b0;
          fail_count_d = '0;
          first_fail_d = '0;
`ifdef ATPG_SEQ_MISR_EN
          sig_d        = '0;
`endif
          if (num_vec == '0) begin
            state_d = S_FINISH;
          end else begin
            n_d     = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
            state_d = S_APPLY;
          end
        end else if (ld_en) begin
          tbl_we = 1'b1;
        end
      end
      S_APPLY: begin
        dut_in_d = stim_mem[idx_q];
        cnt_d    = SETTLE_V;
        state_d  = (SETTLE > 0) ? S_SETTLE : S_CAPTURE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        cap_we = 1'b1;
`ifdef ATPG_SEQ_MISR_EN
        sig_d  = {sig_q[OUT_W-2:0], sig_q[OUT_W-1] ^ sig_q[0]} ^ dut_out;
`endif
        if (mismatch) begin
          fail_d = 1'b1;
          if (fail_count_q != '1) begin
            fail_count_d = fail_count_q + ONE_V;
          end
          if (!fail_q) begin
            first_fail_d = idx_q;
          end
        end
        if (last_vec) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_APPLY;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      n_q          <= '0;
      cnt_q        <= '0;
      dut_in_q     <= '0;
      fail_q       <= 1'b0;
      fail_count_q <= '0;
      first_fail_q <= '0;
      done_q       <= 1'b0;
`ifdef ATPG_SEQ_MISR_EN
      sig_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      dut_in_q     <= dut_in_d;
      fail_q       <= fail_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      done_q       <= done_d;
`ifdef ATPG_SEQ_MISR_EN
      sig_q        <= sig_d;
`endif
    end
  end

  // Table and capture storage carry no reset so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      stim_mem[ld_addr] <= ld_stim;
      exp_mem[ld_addr]  <= ld_exp;
      mask_mem[ld_addr] <= ld_mask;
    end
    if (cap_we) begin
      cap_mem[idx_q] <= dut_out;
    end
  end

  assign dut_in     = dut_in_q;
  assign cap_data   = cap_mem[cap_addr];
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_count = fail_count_q;
  assign first_fail = first_fail_q;
`ifdef ATPG_SEQ_MISR_EN
  assign signature  = sig_q;
`endif

endmodule

// File: tb/tb_atpg_vector_sequencer.sv
// Bench for atpg_vector_sequencer: timeline model of a run checked every cycle, plus literal latency/status checks.
`timescale 1ns/1ps
module tb_atpg_vector_sequencer;
  localparam int IN_W   = 60;
  localparam int OUT_W  = 26;
  localparam int DEPTH  = 16;
  localparam int SETTLE = 1;
  localparam int AW     = 4;
  localparam int SLOT   = SETTLE + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ld_en = 1'b0;
  logic [AW-1:0]    ld_addr = '0;
  logic [IN_W-1:0]  ld_stim = '0;
  logic [OUT_W-1:0] ld_exp = '0;
  logic [OUT_W-1:0] ld_mask = '0;
  logic             start = 1'b0;
  logic [AW:0]      num_vec = '0;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic [AW-1:0]    cap_addr = '0;
  logic [OUT_W-1:0] cap_data;
  logic             busy, done, fail;
  logic [AW:0]      fail_count;
  logic [AW-1:0]    first_fail;
`ifdef ATPG_SEQ_MISR_EN
  logic [OUT_W-1:0] signature;
  logic [OUT_W-1:0] sig_first;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit cmp_on = 1'b0;

  logic [IN_W-1:0] vecs [16] = '{
    60'h123456789ABCDEF, 60'hFEDCBA987654321, 60'h000000000000000, 60'hFFFFFFFFFFFFFFF,
    60'hAAAAAAAAAAAAAAA, 60'h555555555555555, 60'h0F0F0F0F0F0F0F0, 60'hF0F0F0F0F0F0F0F,
    60'h00000000FFFFFFF, 60'hFFFFFFF00000000, 60'h13579BDF02468AC, 60'hDEADBEEFCAFE123,
    60'h800000000000001, 60'h0123FEDC4567BA9, 60'h3C3C3C3C3C3C3C3, 60'h7777777700000FF};

  // bench copy of the table, and the snapshot taken when a run starts
  logic [IN_W-1:0]  t_stim [DEPTH];
  logic [OUT_W-1:0] t_exp  [DEPTH];
  logic [OUT_W-1:0] t_mask [DEPTH];
  bit               run_on = 1'b0;
  int               run_k = 0;
  int               run_n = 0;
  logic [IN_W-1:0]  r_stim [DEPTH];
  bit               r_mm   [DEPTH];
  logic [IN_W-1:0]  din_before = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OUT_W-1:0] ref_fn(input logic [IN_W-1:0] x);
    logic [OUT_W-1:0] r;
    r = x[25:0] ^ x[51:26] ^ {x[59:52], x[17:0]} ^ (x[51:26] & {x[59:52], x[59:42]});
    return r;
  endfunction

  assign dut_out = ref_fn(dut_in);

  atpg_vector_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(SETTLE)) u_dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_stim(ld_stim),
    .ld_exp(ld_exp), .ld_mask(ld_mask), .start(start), .num_vec(num_vec),
    .dut_in(dut_in), .dut_out(dut_out), .cap_addr(cap_addr), .cap_data(cap_data),
    .busy(busy), .done(done), .fail(fail), .fail_count(fail_count), .first_fail(first_fail)
`ifdef ATPG_SEQ_MISR_EN
    , .signature(signature)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Run timeline: j = edges since the start sample. Vector v is driven at j=v*SLOT+1
  // and judged at j=(v+1)*SLOT; busy spans j=0..n*SLOT, done is j=n*SLOT+1.
  function automatic int m_applied();
    int j = cyc - run_k;
    int a;
    if (!run_on || j < 1) return 0;
    a = (j - 1) / SLOT + 1;
    return (a > run_n) ? run_n : a;
  endfunction

  function automatic int m_captured();
    int a;
    if (!run_on) return 0;
    a = (cyc - run_k) / SLOT;
    return (a > run_n) ? run_n : a;
  endfunction

  function automatic logic m_busy();
    return run_on && ((cyc - run_k) <= run_n * SLOT);
  endfunction

  function automatic logic m_done();
    return run_on && ((cyc - run_k) == run_n * SLOT + 1);
  endfunction

  function automatic logic [IN_W-1:0] m_din();
    int a = m_applied();
    return (a > 0) ? r_stim[a-1] : din_before;
  endfunction

  function automatic int m_fcount();
    int c = 0;
    for (int v = 0; v < m_captured(); v++) if (r_mm[v]) c++;
    return c;
  endfunction

  function automatic int m_ffirst();
    for (int v = 0; v < m_captured(); v++) if (r_mm[v]) return v;
    return 0;
  endfunction

`ifdef ATPG_SEQ_MISR_EN
  function automatic logic [OUT_W-1:0] m_sig();
    logic [OUT_W-1:0] s = '0;
    for (int v = 0; v < m_captured(); v++)
      s = {s[OUT_W-2:0], s[OUT_W-1] ^ s[0]} ^ ref_fn(r_stim[v]);
    return s;
  endfunction
`endif

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy", busy, m_busy());
      chk("done", done, m_done());
      chk("dut_in", dut_in, m_din());
      chk("fail", fail, m_fcount() > 0);
      chk("fail_count", fail_count, m_fcount());
      chk("first_fail", first_fail, m_ffirst());
`ifdef ATPG_SEQ_MISR_EN
      chk("signature", signature, m_sig());
`endif
    end
  end

  task automatic load(input int a, input logic [IN_W-1:0] s, input logic [OUT_W-1:0] e,
                      input logic [OUT_W-1:0] m);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a[AW-1:0]; ld_stim = s; ld_exp = e; ld_mask = m;
    @(posedge clk);
    #1 ld_en = 1'b0;
    t_stim[a] = s; t_exp[a] = e; t_mask[a] = m;
  endtask

  task automatic run_start(input int nv);
    logic [IN_W-1:0] cur;
    @(negedge clk);
    cur = m_din();
    start = 1'b1; num_vec = nv[AW:0];
    @(posedge clk);
    #1 start = 1'b0;
    din_before = cur;
    run_on = 1'b1;
    run_k  = cyc;
    run_n  = (nv > DEPTH) ? DEPTH : nv;
    for (int v = 0; v < DEPTH; v++) begin
      r_stim[v] = t_stim[v];
      r_mm[v]   = |((ref_fn(t_stim[v]) ^ t_exp[v]) & t_mask[v]);
    end
  endtask

  task automatic wait_done(input string name, input int lat_exp, input int busy_exp);
    int bc = 0;
    int lat = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        seen = 1'b1;
        lat = cyc - run_k;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: done not seen within 200 cycles", name);
    end else begin
      chk({name, " latency"}, lat, lat_exp);
      if (busy_exp >= 0) chk({name, " busy cycles"}, bc, busy_exp);
    end
  endtask

  task automatic chk_caps(input int n);
    for (int v = 0; v < n; v++) begin
      cap_addr = v[AW-1:0];
      #1 chk("cap_data", cap_data, ref_fn(t_stim[v]));
    end
  endtask

  initial begin
    cmp_on = 1'b1;
    #2;
    chk("reset dut_in", dut_in, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset fail", fail, 0);
    chk("reset fail_count", fail_count, 0);
    chk("reset first_fail", first_fail, 0);
    #10 rst_n = 1'b1;

    for (int v = 0; v < 10; v++) load(v, vecs[v], ref_fn(vecs[v]), '1);

    // all-pass run over 10 vectors
    run_start(10);
    wait_done("pass10", 31, 31);
    chk("pass10 fail", fail, 0);
    chk("pass10 fail_count", fail_count, 0);
    chk_caps(10);

    // single flipped expected bit
    load(3, vecs[3], ref_fn(vecs[3]) ^ 26'h1, '1);
    run_start(10);
    wait_done("flip3", 31, 31);
    chk("flip3 fail", fail, 1);
    chk("flip3 fail_count", fail_count, 1);
    chk("flip3 first_fail", first_fail, 3);

    // same flip hidden by the mask
    load(3, vecs[3], ref_fn(vecs[3]) ^ 26'h1, 26'h3FFFFFE);
    run_start(10);
    wait_done("masked3", 31, 31);
    chk("masked3 fail", fail, 0);
    chk("masked3 fail_count", fail_count, 0);

    // zero-length run
    run_start(0);
    wait_done("nv0", 1, 1);
    chk("nv0 fail_count", fail_count, 0);

    // oversize request clamps to DEPTH; entry 12 mismatches in its top bit
    for (int v = 10; v < 16; v++)
      load(v, vecs[v], ref_fn(vecs[v]) ^ ((v == 12) ? 26'h2000000 : 26'h0), '1);
    run_start(20);
    wait_done("nv20", 49, 49);
    chk("nv20 fail_count", fail_count, 1);
    chk("nv20 first_fail", first_fail, 12);
    chk_caps(16);

    // start and table write while busy must be ignored
    run_start(4);
    repeat (3) @(negedge clk);
    start = 1'b1; num_vec = 5'd2;
    ld_en = 1'b1; ld_addr = '0; ld_stim = 60'hBADBADBADBADBAD; ld_exp = 26'h155AAAA; ld_mask = '1;
    @(posedge clk);
    #1 start = 1'b0; ld_en = 1'b0;
    wait_done("busy_ignore", 13, -1);
    run_start(4);
    wait_done("after_ignore", 13, 13);
    chk("after_ignore fail", fail, 0);
    chk_caps(4);

    // reset in the middle of a run
    run_start(8);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    run_on = 1'b0;
    din_before = '0;
    #1;
    chk("midrst dut_in", dut_in, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst fail", fail, 0);
    chk("midrst fail_count", fail_count, 0);
    chk("midrst first_fail", first_fail, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // final run, repeated to confirm a repeatable signature
    run_start(10);
    wait_done("final_a", 31, 31);
`ifdef ATPG_SEQ_MISR_EN
    sig_first = signature;
`endif
    run_start(10);
    wait_done("final_b", 31, 31);
    chk("final fail_count", fail_count, 0);
`ifdef ATPG_SEQ_MISR_EN
    chk("signature rerun", signature, sig_first);
`endif

    @(negedge clk);
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atpg_vector_sequencer.md
Name: atpg_vector_sequencer

Overview:
- Synthesizable, parametrised successor to our fixed-width ISCAS85 benches (c880: 60 in / 26 out / 10 vectors).
- Holds a loadable table of stimulus, expected and mask vectors and applies them one per slot to a combinational DUT.
- Captures each response and compares it against the expected vector under the mask.
- Reports pass/fail, fail count and first failing index, so ATPG pattern sets can run on-chip or in a clocked bench.

Parameters:
- IN_W, 60, DUT input width (stimulus vector width)
- OUT_W, 26, DUT output width (response/expected/mask width)
- DEPTH, 16, vector table entries (power of 2, >=2)
- SETTLE, 1, idle cycles between driving a vector and capturing the response (0..15)
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_en  in  1  table write strobe; ignored while busy=1
- ld_addr  in  AW  table write address
- ld_stim  in  IN_W  stimulus word
- ld_exp  in  OUT_W  expected response word
- ld_mask  in  OUT_W  compare mask; 1 = bit checked
- start  in  1  begin a run; sampled in IDLE only
- num_vec  in  AW+1  vectors to run; sampled with start
- dut_in  out  IN_W  drives DUT inputs
- dut_out  in  OUT_W  DUT outputs
- cap_addr  in  AW  capture memory read address
- cap_data  out  OUT_W  captured response at cap_addr, combinational read
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- fail  out  1  at least one mismatch in last run
- fail_count  out  AW+1  mismatching vectors in last run
- first_fail  out  AW  index of first mismatching vector

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - dut_in, busy, done, fail, fail_count and first_fail are all 0.
  - Table and capture contents are not reset.
- Reset mid-run aborts immediately. No done pulse follows.
- FSM states: IDLE, APPLY, SETTLE, CAPTURE, FINISH.
- IDLE:
  - start=1 and num_vec>0: latch n=min(num_vec,DEPTH), set idx=0, clear fail, fail_count and first_fail, go to APPLY.
  - start=1 and num_vec=0: go directly to FINISH, with status cleared.
- APPLY (1 cycle):
  - Register dut_in <= stim[idx].
  - Load the settle counter with SETTLE.
  - Next state is SETTLE if SETTLE>0, else CAPTURE.
- SETTLE: decrement the counter each cycle; go to CAPTURE when it reaches 1.
- CAPTURE (1 cycle):
  - Store cap[idx] <= dut_out.
  - Mismatch = |((dut_out ^ exp[idx]) & mask[idx]).
  - On mismatch: fail <= 1, fail_count <= fail_count+1 (saturating at all-ones). If this is the first mismatch of the run, first_fail <= idx.
  - If idx==n-1, go to FINISH; else idx <= idx+1 and go to APPLY.
- FINISH (1 cycle): done=1, then go to IDLE.
- busy=1 in APPLY, SETTLE, CAPTURE and FINISH.
- Latency: done is asserted exactly 1 + n*(SETTLE+2) cycles after the start sample edge.
- dut_in holds the last applied vector after the run until the next APPLY or reset.
- fail, fail_count and first_fail hold until the next start.
- start while busy is ignored.
- ld_en while busy is ignored; table contents are unchanged.
- Table writes in IDLE take effect next cycle, so a write and start in the same cycle use the old contents at that address.
- A mask of all zeros means the vector always passes.
- idx wraps never, because n<=DEPTH.

Optional Feature:
- Macro: ATPG_SEQ_MISR_EN.
- When defined, adds output signature [OUT_W-1:0]:
  - MISR with polynomial taps at bits OUT_W-1 and 0.
  - Cleared to 0 at start.
  - Each CAPTURE: sig <= {sig[OUT_W-2:0], sig[OUT_W-1]^sig[0]} ^ dut_out.
  - Holds after FINISH.
  - Reset value 0.
- When undefined: no signature port and no MISR logic.
- All other behaviour is identical in both builds.

Test Plan:
- Passing run: load 10 c880-width vectors with exp equal to a reference model, masks all-ones, num_vec=10, SETTLE=1 -> done at 31 cycles after start; fail=0; fail_count=0; cap[0..9] == exp.
- Single mismatch: exp[3] bit 0 flipped -> fail=1, fail_count=1, first_fail=3.
- Masked mismatch: same flip with mask[3] bit 0 =0 -> fail=0, fail_count=0.
- Edge run lengths: num_vec=0 -> done 1 cycle after start, busy high for 1 cycle. num_vec=20 with DEPTH=16 -> 16 vectors applied, done at 1+16*3=49 cycles.
- Ignored controls and reset: start and ld_en pulsed while busy -> no restart, table unchanged. rst_n low mid-run -> all outputs 0 asynchronously, no done.
- MISR (ATPG_SEQ_MISR_EN defined): signature equals the bench-computed MISR over the captured responses; a rerun with identical stimulus gives an identical signature.
